// File: rtl/window_streamer_pkg.sv
// Shared definitions for the window streamer front end.
// Holds the window geometry, the sample/window types, the stream FSM
// encoding and a helper that reorders a window oldest-sample-first.
package window_streamer_pkg;

  localparam int logNrns = 5;
  localparam int NRNS    = 2 ** logNrns;
  localparam int DW      = 8;

  typedef logic [DW-1:0]            sample_t;
  typedef logic [NRNS-1:0][DW-1:0]  window_t;
  typedef logic [logNrns-1:0]       idx_t;
  typedef logic [logNrns:0]         fill_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam idx_t IDX_LAST = idx_t'(NRNS - 1);

  // win[0] is the newest sample; frames are sent oldest first, so the
  // snapshot buffer stores entry i = win[NRNS-1-i].
  function automatic window_t oldest_first(input window_t w);
    window_t r;
    for (int i = 0; i < NRNS; i++) begin
      r[i] = w[NRNS-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/window_streamer_window.sv
// Sliding sample window with fill counter.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   sample_in     incoming sample
//   sample_valid  shift sample_in into the window this cycle
//   win_next      window as it will be after this cycle's shift (newest at [0])
//   full          fill count has reached NRNS (before this cycle's sample)
//   almost_full   fill count is NRNS-1, so an accepted sample fills the window
module sample_window
  import window_streamer_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  output window_t       win_next,
  output logic          full,
  output logic          almost_full
);

  window_t win_q;
  fill_t   fill;

  always_comb begin
    win_next = win_q;
    if (sample_valid) begin
      win_next = {win_q[NRNS-2:0], sample_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
      fill  <= '0;
    end else if (sample_valid) begin
      win_q <= win_next;
      if (!full) begin
        fill <= fill + 1'b1;
      end
    end
  end

  assign full        = (fill == fill_t'(NRNS));
  assign almost_full = (fill == fill_t'(NRNS - 1));

endmodule

// File: rtl/window_streamer.sv
// Window streamer: snapshots the sliding sample window every STRIDE
// accepted samples and serializes it one sample per clock, oldest first,
// with a one-deep pending buffer so frames can run back to back.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   sample_in     incoming sample, sample_valid marks it accepted
//   x_data/x_idx  serialized sample and its index within the frame
//   x_valid       x_data/x_idx valid
//   x_first       index 0 (bias-add cycle), x_last index NRNS-1
//   overrun       sticky: a snapshot was dropped because pending was full
//
// state  | meaning
// IDLE   | no frame in flight, waiting for a trigger
// STREAM | emitting snap[idx], idx = sample currently on x_data
module window_streamer
  import window_streamer_pkg::*;
#(
  parameter int STRIDE = 8
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic [DW-1:0]      sample_in,
  input  logic               sample_valid,
  output logic [DW-1:0]      x_data,
  output logic [logNrns-1:0] x_idx,
  output logic               x_valid,
  output logic               x_first,
  output logic               x_last,
  output logic               overrun
);

  localparam fill_t STRIDE_LAST = fill_t'(STRIDE - 1);

  window_t win_next;
  window_t new_snap;
  logic    full;
  logic    almost_full;
  fill_t   stride_cnt;
  logic    trigger;

  state_t  state, state_nxt;
  idx_t    idx, idx_nxt;
  window_t snap, snap_nxt;
  window_t pend, pend_nxt;
  logic    pend_v, pend_v_nxt;
  logic    ovr_nxt;
  logic    stream_nxt;

  sample_window u_window (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .win_next     (win_next),
    .full         (full),
    .almost_full  (almost_full)
  );

  // First full window triggers; afterwards every STRIDE-th accepted sample.
  assign trigger  = sample_valid &
                    (almost_full | (full & (stride_cnt == STRIDE_LAST)));
  assign new_snap = oldest_first(win_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      stride_cnt <= '0;
    end else if (sample_valid) begin
      stride_cnt <= trigger ? '0 : stride_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    snap_nxt   = snap;
    pend_nxt   = pend;
    pend_v_nxt = pend_v;
    ovr_nxt    = overrun;
    case (state)
      IDLE: begin
        idx_nxt = '0;
        if (trigger) begin
          snap_nxt  = new_snap;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (idx == IDX_LAST) begin
          idx_nxt = '0;
          if (pend_v) begin
            // Older pending frame goes first; a coincident trigger refills pending.
            snap_nxt   = pend;
            pend_v_nxt = trigger;
            if (trigger) begin
              pend_nxt = new_snap;
            end
          end else if (trigger) begin
            snap_nxt = new_snap;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          idx_nxt = idx + 1'b1;
          if (trigger) begin
            if (!pend_v) begin
              pend_nxt   = new_snap;
              pend_v_nxt = 1'b1;
            end else begin
              ovr_nxt = 1'b1;
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  assign stream_nxt = (state_nxt == STREAM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      snap    <= '0;
      pend    <= '0;
      pend_v  <= 1'b0;
      overrun <= 1'b0;
      x_valid <= 1'b0;
      x_idx   <= '0;
      x_data  <= '0;
      x_first <= 1'b0;
      x_last  <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      snap    <= snap_nxt;
      pend    <= pend_nxt;
      pend_v  <= pend_v_nxt;
      overrun <= ovr_nxt;
      x_valid <= stream_nxt;
      x_idx   <= stream_nxt ? idx_nxt : '0;
      x_data  <= stream_nxt ? snap_nxt[idx_nxt] : '0;
      x_first <= stream_nxt && (idx_nxt == '0);
      x_last  <= stream_nxt && (idx_nxt == IDX_LAST);
    end
  end

endmodule

// File: doc/window_streamer.md
Name: window_streamer

Overview:
- Front end of the serial neuron datapath.
- Collects the incoming neural sample stream into a sliding window of NRNS samples.
- Every STRIDE new samples, snapshots the window and streams it out one sample per clock, index 0..NRNS-1. The index is aligned to the neuron's weight-select counter, and x_first marks the bias-add cycle.
- Holds one pending snapshot so frames can be delivered back-to-back without gaps.

Parameters:
- logNrns, 5, bits for neuron input index; NRNS = 2**logNrns = 32 window length.
- DW, 8, sample width in bits (two's complement, passed through unmodified).
- STRIDE, 8, new samples between consecutive windows; legal range 1..NRNS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- sample_in  in  DW  incoming sample
- sample_valid  in  1  sample_in accepted this cycle; always accepted, no backpressure
- x_data  out  DW  serialized window sample
- x_idx  out  logNrns  index of x_data within frame
- x_valid  out  1  x_data/x_idx valid
- x_first  out  1  high with idx 0 (bias enable)
- x_last  out  1  high with idx NRNS-1
- overrun  out  1  sticky: a snapshot was dropped

Behaviour:
- Reset:
  - All outputs 0; fill count 0; stride count 0; state IDLE; pending empty; window contents 0.
  - Reset mid-frame aborts the frame immediately: x_valid is 0 the next cycle and the partial frame is never resumed.
- Window:
  - On sample_valid: win[0]<=sample_in; win[k]<=win[k-1].
  - fill counts accepted samples and saturates at NRNS.
- Trigger (evaluated in the cycle a sample is accepted):
  - Fires when the accepted sample brings fill to NRNS, i.e. the first full window.
  - After that, fires when fill==NRNS and stride_cnt==STRIDE-1.
  - stride_cnt resets to 0 on each trigger and increments per accepted sample otherwise.
  - The snapshot is the window including the sample accepted this cycle.
- Frame ordering: x_idx 0 = oldest sample (post-shift win[NRNS-1]); x_idx NRNS-1 = newest sample.
- State machine:
  - IDLE: on trigger, load snap; next cycle enter STREAM with idx 0 (latency 1 clock, trigger to x_first).
  - STREAM: x_valid=1 and x_data=snap[idx]; idx increments each cycle, wrapping NRNS-1 -> 0.
- At idx NRNS-1, choose the next snapshot in this priority:
  1. Pending valid: load pending into snap, clear pending, next cycle idx 0 (gapless). A trigger in this same cycle goes to pending.
  2. Else trigger in this cycle: load the new snapshot directly into snap and continue gapless.
  3. Else return to IDLE.
- Trigger in STREAM at idx < NRNS-1:
  - Pending empty: store into pending.
  - Pending full: drop the new snapshot (pending keeps the older one) and set overrun.
- overrun clears only on rst.
- x_first = x_valid & idx==0; x_last = x_valid & idx==NRNS-1. All outputs are registered.
- sample_valid gaps stall only the window and trigger logic; an in-flight frame keeps streaming from snap.

Decomposition:
- Shared package: logNrns, NRNS, DW, STREAM/IDLE state encoding.
- Sub-module sample_window: shift register plus fill counter. Outputs the post-shift window and a full flag.
- window_streamer holds the stride/trigger logic, snap/pending buffers, FSM and output registers.

Test Plan:
- After reset, drive sample_valid with 1..32 back-to-back -> trigger on the sample of value 32; next cycle x_first=1, x_idx=0, x_data=1; 32 consecutive x_valid cycles with x_data 1..32, x_last with x_data=32; then x_valid=0.
- Continue with 33..40 (STRIDE=8) -> one frame with x_data 9..40; no frame earlier than the sample of value 40.
- STRIDE=1 with continuous samples -> first frame is samples 1..32; pending captures the window ending at 33; samples 34..63 are dropped and overrun=1 at sample 34. Frames are gapless: x_first the cycle after x_last.
- Insert sample_valid gaps (1 valid every 3 cycles) during a frame -> frame still 32 contiguous cycles, content unchanged; next trigger counts only valid samples.
- Assert rst at x_idx=10 -> cycle after rst: x_valid=0, overrun=0; 31 new samples give no frame, the 32nd triggers one.
- Trigger coinciding with x_last and pending empty -> next cycle x_first with the new window, no idle cycle, overrun stays 0.
